// File: rtl/cordic_seq_ctrl.sv
// Iteration sequencer for the sequential CORDIC core: load strobe, iteration
// counter (ROM address / shift amount), micro-rotation direction and done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; mode latched on accept
// S_LOAD | one-cycle load strobe, counter cleared
// S_ITER | one micro-rotation per enabled cycle, counter = iteration
// S_DONE | one-cycle done pulse; start here chains the next conversion
module cordic_seq_ctrl #(
   parameter int NITER = 16,
   parameter int CNTW  = 5
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_enable,
   input  logic            i_start,
   input  logic            i_mode,
   input  logic            i_z_sign,
   input  logic            i_y_sign,
   output logic            o_busy,
   output logic            o_load,
   output logic            o_iter_en,
   output logic [CNTW-1:0] o_rom_addr,
   output logic [CNTW-1:0] o_shift,
   output logic            o_dir,
   output logic            o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NITER - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CNTW-1:0] r_cnt;
   logic            r_mode;
   logic            w_last;
   logic            w_accept;

   assign w_last   = (r_cnt == LAST_CNT);
   assign w_accept = i_enable && i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept)
            r_mode <= i_mode;
         // counter only moves on enabled cycles so a stall never drops or repeats an iteration
         if (i_enable) begin
            if (r_state == S_LOAD)
               r_cnt <= '0;
            else if ((r_state == S_ITER) && !w_last)
               r_cnt <= r_cnt + CNTW'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_enable) begin
         case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_ITER;
            S_ITER:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = i_start ? S_LOAD : S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_busy     = (r_state == S_LOAD) || (r_state == S_ITER);
      o_load     = i_enable && (r_state == S_LOAD);
      o_iter_en  = i_enable && (r_state == S_ITER);
      o_done     = i_enable && (r_state == S_DONE);
      o_rom_addr = r_cnt;
      o_shift    = r_cnt;
      o_dir      = 1'b0;
      if (o_iter_en)
         o_dir = r_mode ? i_y_sign : ~i_z_sign;
   end

endmodule
